// File: rtl/hazard_flush_ctrl_pkg.sv
// rtl/hazard_flush_ctrl_pkg.sv - shared pipeline control types and constants
package hazard_flush_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } hz_state_t;

  localparam int REG_ADDR_W_DEF = 3;
  localparam int ZERO_REG       = 0;

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// rtl/hazard_flush_ctrl_if.sv - hazard inputs and pipeline control outputs
interface hazard_flush_ctrl_if
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
);

  logic                  branch_taken_ex;
  logic                  load_ex;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic                  flush_ifid;
  logic                  flush_idex;
  logic                  stall_pc;
  logic                  stall_ifid;
  logic                  busy;
  logic [CNT_W-1:0]      flush_events;
  logic [CNT_W-1:0]      stall_events;

  modport master (
    output branch_taken_ex, load_ex, ex_rd, id_rs, id_rt, id_rs_used, id_rt_used,
    input  flush_ifid, flush_idex, stall_pc, stall_ifid, busy, flush_events, stall_events
  );

  modport slave (
    input  branch_taken_ex, load_ex, ex_rd, id_rs, id_rt, id_rs_used, id_rt_used,
    output flush_ifid, flush_idex, stall_pc, stall_ifid, busy, flush_events, stall_events
  );

endinterface

// File: rtl/hazard_flush_ctrl_sat_event_counter.sv
// rtl/hazard_flush_ctrl_sat_event_counter.sv - saturating event counter
module sat_event_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - branch flush / load-use stall controller
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W         = REG_ADDR_W_DEF,
  parameter int FLUSH_LEN          = 2,
  parameter int STALL_LEN          = 1,
  parameter int CNT_W              = 16,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input logic          clock,
  input logic          reset,
  hazard_flush_ctrl_if.slave hz
);

  localparam logic [3:0] FLUSH_REM = 4'(FLUSH_LEN - 1);
  localparam logic [3:0] STALL_REM = 4'(STALL_LEN - 1);

  hz_state_t  state, state_next;
  logic [3:0] remain, remain_next;
  logic       br, luse, rs_hit, rt_hit, rd_is_zero;
  logic       flush_inc, stall_inc;

  assign br         = hz.branch_taken_ex;
  assign rs_hit     = hz.id_rs_used && (hz.id_rs == hz.ex_rd);
  assign rt_hit     = hz.id_rt_used && (hz.id_rt == hz.ex_rd);
  assign rd_is_zero = (ZERO_REG_HARDWIRED != 0) && (hz.ex_rd == REG_ADDR_W'(ZERO_REG));
  assign luse       = hz.load_ex && (rs_hit || rt_hit) && !rd_is_zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      remain <= 4'd0;
    end else begin
      state  <= state_next;
      remain <= remain_next;
    end
  end

  // IDLE and a branch in STALL react in the detect cycle; otherwise outputs follow state.
  always_comb begin
    state_next     = state;
    remain_next    = remain;
    hz.flush_ifid  = 1'b0;
    hz.flush_idex  = 1'b0;
    hz.stall_pc    = 1'b0;
    hz.stall_ifid  = 1'b0;
    hz.busy        = 1'b0;
    flush_inc      = 1'b0;
    stall_inc      = 1'b0;
    if (!reset) begin
      hz.busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (br) begin
            hz.flush_ifid = 1'b1;
            hz.flush_idex = 1'b1;
            flush_inc     = 1'b1;
            if (FLUSH_LEN > 1) begin
              state_next  = FLUSH;
              remain_next = FLUSH_REM;
            end
          end else if (luse) begin
            hz.stall_pc   = 1'b1;
            hz.stall_ifid = 1'b1;
            hz.flush_idex = 1'b1;
            stall_inc     = 1'b1;
            if (STALL_LEN > 1) begin
              state_next  = STALL;
              remain_next = STALL_REM;
            end
          end
        end
        FLUSH: begin
          hz.flush_ifid = 1'b1;
          hz.flush_idex = 1'b1;
          if (remain <= 4'd1) begin
            state_next  = IDLE;
            remain_next = 4'd0;
          end else begin
            remain_next = remain - 4'd1;
          end
        end
        STALL: begin
          if (br) begin
            hz.flush_ifid = 1'b1;
            hz.flush_idex = 1'b1;
            flush_inc     = 1'b1;
            if (FLUSH_LEN > 1) begin
              state_next  = FLUSH;
              remain_next = FLUSH_REM;
            end else begin
              state_next  = IDLE;
              remain_next = 4'd0;
            end
          end else begin
            hz.stall_pc   = 1'b1;
            hz.stall_ifid = 1'b1;
            hz.flush_idex = 1'b1;
            if (remain <= 4'd1) begin
              state_next  = IDLE;
              remain_next = 4'd0;
            end else begin
              remain_next = remain - 4'd1;
            end
          end
        end
        default: begin
          state_next  = IDLE;
          remain_next = 4'd0;
        end
      endcase
    end
  end

  sat_event_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (flush_inc),
    .count (hz.flush_events)
  );

  sat_event_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (stall_inc),
    .count (hz.stall_events)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - directed scoreboard bench for hazard_flush_ctrl
module tb_hazard_flush_ctrl;

  logic       clock = 1'b0;
  logic       rst_a, rst_b;
  logic       br, ld, rsu, rtu;
  logic [2:0] rd, rs, rt;

  typedef struct {
    string       tag;
    bit          dsel;
    logic        fi, fx, st, bz;
    logic [31:0] fe, se;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   dsel  = 1'b0;

  always #5 clock = ~clock;

  hazard_flush_ctrl_if #(.REG_ADDR_W(3), .CNT_W(16)) if_a ();
  hazard_flush_ctrl_if #(.REG_ADDR_W(3), .CNT_W(2))  if_b ();

  assign if_a.branch_taken_ex = br;
  assign if_a.load_ex         = ld;
  assign if_a.ex_rd           = rd;
  assign if_a.id_rs           = rs;
  assign if_a.id_rt           = rt;
  assign if_a.id_rs_used      = rsu;
  assign if_a.id_rt_used      = rtu;
  assign if_b.branch_taken_ex = br;
  assign if_b.load_ex         = ld;
  assign if_b.ex_rd           = rd;
  assign if_b.id_rs           = rs;
  assign if_b.id_rt           = rt;
  assign if_b.id_rs_used      = rsu;
  assign if_b.id_rt_used      = rtu;

  hazard_flush_ctrl #(
    .REG_ADDR_W(3), .FLUSH_LEN(2), .STALL_LEN(1), .CNT_W(16), .ZERO_REG_HARDWIRED(1)
  ) dut_a (
    .clock (clock),
    .reset (rst_a),
    .hz    (if_a.slave)
  );

  hazard_flush_ctrl #(
    .REG_ADDR_W(3), .FLUSH_LEN(4), .STALL_LEN(3), .CNT_W(2), .ZERO_REG_HARDWIRED(1)
  ) dut_b (
    .clock (clock),
    .reset (rst_b),
    .hz    (if_b.slave)
  );

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic set_in(input logic b, input logic l, input logic [2:0] d,
                        input logic [2:0] s, input logic su,
                        input logic [2:0] t, input logic tu);
    br = b; ld = l; rd = d; rs = s; rsu = su; rt = t; rtu = tu;
  endtask

  task automatic idle_in();
    set_in(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic step(input string tag, input logic fi, input logic fx,
                      input logic st, input logic bz, input int fe, input int se);
    exp_t e, got;
    e.tag = tag; e.dsel = dsel;
    e.fi = fi; e.fx = fx; e.st = st; e.bz = bz;
    e.fe = 32'(fe); e.se = 32'(se);
    sb.push_back(e);
    #3;
    if (sb.size() == 0) begin
      check(tag, "scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      if (!got.dsel) begin
        check(got.tag, "flush_ifid",   {31'd0, if_a.flush_ifid}, {31'd0, got.fi});
        check(got.tag, "flush_idex",   {31'd0, if_a.flush_idex}, {31'd0, got.fx});
        check(got.tag, "stall_pc",     {31'd0, if_a.stall_pc},   {31'd0, got.st});
        check(got.tag, "stall_ifid",   {31'd0, if_a.stall_ifid}, {31'd0, got.st});
        check(got.tag, "busy",         {31'd0, if_a.busy},       {31'd0, got.bz});
        check(got.tag, "flush_events", {16'd0, if_a.flush_events}, got.fe);
        check(got.tag, "stall_events", {16'd0, if_a.stall_events}, got.se);
      end else begin
        check(got.tag, "flush_ifid",   {31'd0, if_b.flush_ifid}, {31'd0, got.fi});
        check(got.tag, "flush_idex",   {31'd0, if_b.flush_idex}, {31'd0, got.fx});
        check(got.tag, "stall_pc",     {31'd0, if_b.stall_pc},   {31'd0, got.st});
        check(got.tag, "stall_ifid",   {31'd0, if_b.stall_ifid}, {31'd0, got.st});
        check(got.tag, "busy",         {31'd0, if_b.busy},       {31'd0, got.bz});
        check(got.tag, "flush_events", {30'd0, if_b.flush_events}, got.fe);
        check(got.tag, "stall_events", {30'd0, if_b.stall_events}, got.se);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle_in();
    @(posedge clock);
    #1;

    // Device A: FLUSH_LEN=2, STALL_LEN=1, CNT_W=16; B held in reset.
    dsel = 1'b0;
    step("a_rst0", 0, 0, 0, 0, 0, 0);
    set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("a_rst_br", 0, 0, 0, 0, 0, 0);
    rst_a = 1'b0;
    idle_in();
    for (int i = 0; i < 5; i++) step("a_idle", 0, 0, 0, 0, 0, 0);

    set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("a_br_detect", 1, 1, 0, 0, 0, 0);
    idle_in();
    step("a_br_hold", 1, 1, 0, 1, 1, 0);
    step("a_br_done", 0, 0, 0, 0, 1, 0);

    set_in(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    step("a_luse_rs", 0, 1, 1, 0, 1, 0);
    idle_in();
    step("a_luse_done", 0, 0, 0, 0, 1, 1);
    set_in(1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b0);
    step("a_luse_zero", 0, 0, 0, 0, 1, 1);
    set_in(1'b0, 1'b1, 3'd3, 3'd3, 1'b0, 3'd0, 1'b0);
    step("a_luse_unused", 0, 0, 0, 0, 1, 1);
    set_in(1'b0, 1'b1, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1);
    step("a_luse_rt", 0, 1, 1, 0, 1, 1);
    idle_in();
    step("a_luse_rt_done", 0, 0, 0, 0, 1, 2);

    set_in(1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    step("a_both", 1, 1, 0, 0, 1, 2);
    idle_in();
    step("a_both_hold", 1, 1, 0, 1, 2, 2);
    set_in(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    step("a_b2b_luse", 0, 1, 1, 0, 2, 2);
    idle_in();
    step("a_b2b_done", 0, 0, 0, 0, 2, 3);

    set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("a_rst_mid_br", 1, 1, 0, 0, 2, 3);
    idle_in();
    rst_a = 1'b1;
    step("a_rst_mid", 0, 0, 0, 0, 3, 3);
    rst_a = 1'b0;
    step("a_rst_after", 0, 0, 0, 0, 0, 0);

    // Device B: FLUSH_LEN=4, STALL_LEN=3, CNT_W=2; A held in reset.
    rst_a = 1'b1;
    rst_b = 1'b0;
    dsel  = 1'b1;
    idle_in();
    step("b_idle", 0, 0, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    step("b_stall1", 0, 1, 1, 0, 0, 0);
    set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("b_preempt", 1, 1, 0, 1, 0, 1);
    idle_in();
    step("b_pre_fl2", 1, 1, 0, 1, 1, 1);
    step("b_pre_fl3", 1, 1, 0, 1, 1, 1);
    step("b_pre_fl4", 1, 1, 0, 1, 1, 1);
    step("b_pre_done", 0, 0, 0, 0, 1, 1);

    set_in(1'b0, 1'b1, 3'd3, 3'd3, 1'b1, 3'd0, 1'b0);
    step("b_st1", 0, 1, 1, 0, 1, 1);
    idle_in();
    step("b_st2", 0, 1, 1, 1, 1, 2);
    step("b_st3", 0, 1, 1, 1, 1, 2);
    step("b_st_done", 0, 0, 0, 0, 1, 2);

    set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
    step("b_rst_mid_br", 1, 1, 0, 0, 1, 2);
    idle_in();
    rst_b = 1'b1;
    step("b_rst_mid", 0, 0, 0, 0, 2, 2);
    rst_b = 1'b0;
    step("b_rst_after", 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0);
      step("b_sat_br", 1, 1, 0, 0, (k < 3) ? k : 3, 0);
      idle_in();
      for (int j = 0; j < 3; j++)
        step("b_sat_hold", 1, 1, 0, 1, (k + 1 < 3) ? k + 1 : 3, 0);
    end
    step("b_sat_final", 0, 0, 0, 0, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Pipeline hazard controller that produces the flush and stall controls consumed by the IF/ID and ID/EX pipeline registers.
- Detects two hazards:
  - taken branch/jump resolved in EX, which squashes the younger instructions;
  - load-use dependency between the EX and ID stages, which stalls the front end and inserts a bubble.
- Sits beside the decode stage and drives the pipeline registers' flush inputs, the PC enable and the IF/ID hold.
- Also keeps saturating event counters for performance debug.

Parameters:
- REG_ADDR_W, 3: width of register specifiers.
- FLUSH_LEN, 2: total cycles flush is held for a taken branch, including the detect cycle; legal range 1..15.
- STALL_LEN, 1: total stall cycles for a load-use hazard, including the detect cycle; legal range 1..15.
- CNT_W, 16: width of the event counters.
- ZERO_REG_HARDWIRED, 1: when 1, register 0 never creates a dependency.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- branch_taken_ex  in  1  taken branch/jump resolved in EX this cycle.
- load_ex  in  1  instruction in EX is a memory load that writes a register.
- ex_rd  in  REG_ADDR_W  destination register of the EX instruction.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the ID instruction.
- id_rs_used, id_rt_used  in  1  the ID instruction actually reads rs / rt.
- flush_ifid  out  1  clear the IF/ID register this cycle.
- flush_idex  out  1  clear the ID/EX register this cycle (bubble).
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold the IF/ID register.
- busy  out  1  FSM not in IDLE.
- flush_events  out  CNT_W  count of branch flush sequences started.
- stall_events  out  CNT_W  count of load-use stall sequences started.

Behaviour:
- Reset: clock and reset are single-clock; reset is synchronous and active-high.
  - On a clock edge with reset=1: FSM goes to IDLE, the remaining-cycle counter goes to 0, and both event counters go to 0.
  - While reset=1, all control outputs and busy are forced to 0.
  - Reset asserted mid-sequence aborts the sequence; outputs are 0 in that same cycle.
- Hazard terms:
  - luse = load_ex & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)) & ~(ZERO_REG_HARDWIRED & ex_rd==0).
  - br = branch_taken_ex.
- FSM states: IDLE, FLUSH, STALL.
- Outputs are Mealy in IDLE so that a hazard takes effect in its detect cycle; in FLUSH/STALL they depend on state only.
- IDLE:
  - br=1: flush_ifid=1, flush_idex=1, stall outputs 0, flush_events += 1.
    - If FLUSH_LEN>1, go to FLUSH with remain=FLUSH_LEN-1; otherwise stay in IDLE.
  - else luse=1: stall_pc=1, stall_ifid=1, flush_idex=1, flush_ifid=0, stall_events += 1.
    - If STALL_LEN>1, go to STALL with remain=STALL_LEN-1; otherwise stay in IDLE.
  - Neither hazard: all control outputs 0.
  - Priority: br beats luse; simultaneous br and luse gives the branch action only, and stall_events is unchanged.
- FLUSH:
  - flush_ifid=1, flush_idex=1, busy=1.
  - br and luse are ignored, since the stages are being squashed.
  - remain decrements each cycle; when remain==1, return to IDLE on the next edge.
- STALL:
  - stall_pc=1, stall_ifid=1, flush_idex=1, busy=1.
  - br=1 preempts the stall: outputs switch to the FLUSH pattern that same cycle (Mealy on br), flush_events += 1, and the FSM enters FLUSH with remain=FLUSH_LEN-1, or IDLE if FLUSH_LEN==1.
  - Otherwise remain decrements and the FSM returns to IDLE after remain==1.
- Back-to-back sequences: a hazard present in the first IDLE cycle after a sequence starts a new sequence and increments its counter again.
- Counters: saturate at all-ones and never wrap.
- Output invariant: stall_pc==stall_ifid in every cycle.

Decomposition:
- Shared package (pipeline control package) holds:
  - the state encoding typedef {IDLE, FLUSH, STALL};
  - the REG_ADDR_W default;
  - the zero-register constant.
- One natural sub-module: sat_event_counter (width CNT_W, inputs clear and inc), instantiated twice.
- Dependency comparison stays inline.

Test Plan:
- Reset and idle: reset=1 for 2 cycles, then all hazard inputs 0 for 5 cycles -> all outputs 0, both counters 0, busy=0 throughout.
- Branch flush: br pulse at cycle 10, FLUSH_LEN=2 -> flush_ifid and flush_idex high in cycles 10–11, low at 12; flush_events=1; busy=1 in cycle 11 only.
- Load-use hazard: load_ex=1, ex_rd=3, id_rs=3, id_rs_used=1, STALL_LEN=1 -> stall_pc, stall_ifid and flush_idex high for exactly 1 cycle; stall_events=1.
  - Same stimulus with ex_rd=0 -> no stall.
  - Same stimulus with id_rs_used=0 -> no stall.
- Simultaneous hazards: br=1 and luse=1 in the same IDLE cycle -> flush pattern only; flush_events=1, stall_events=0.
  - With STALL_LEN=3: br in the 2nd stall cycle -> flush pattern in that cycle and the next; stall_events=1, flush_events=1.
- Reset mid-FLUSH and saturation:
  - With FLUSH_LEN=4: reset=1 in the 2nd flush cycle -> outputs 0 that cycle, IDLE after the edge.
  - With CNT_W=2: 5 br sequences -> flush_events sticks at 3.
